// File: rtl/mux_nto1_rr.sv
// Registered N-to-1 channel multiplexer with valid/ready handshakes on every port.
// Channel choice is either an external select or a round-robin scan over the valid inputs.
module mux_nto1_rr #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned N     = 4,
    localparam int unsigned SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    input  logic                 out_ready
);

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } state_e;

    state_e            state_q;
    logic [SELW-1:0]   last_q;
    logic              load;
    logic              gv;
    logic [SELW-1:0]   g;
    logic [WIDTH-1:0]  gdata;

    function automatic logic [SELW-1:0] rr_idx(input logic [SELW-1:0] base,
                                               input int unsigned    off);
        return SELW'((32'(base) + off) % N);
    endfunction

    assign out_valid = (state_q == StFull);
    assign load      = ~out_valid | out_ready;

    always_comb begin
        g  = '0;
        gv = 1'b0;
        if (!mode) begin
            g = sel;
            if (32'(sel) < N) begin
                gv = in_valid[sel];
            end
        end else begin
            // Descending scan so the nearest valid channel after last_q is the final winner.
            for (int unsigned k = N; k >= 1; k--) begin
                if (in_valid[rr_idx(last_q, k)]) begin
                    g = rr_idx(last_q, k);
                end
            end
            gv = |in_valid;
        end
    end

    always_comb begin
        gdata = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (g == SELW'(i)) begin
                gdata = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // rst_n gates the accept so no transfer can be seen while reset is asserted.
    always_comb begin
        in_ready = '0;
        if (rst_n && load && gv) begin
            in_ready[g] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StEmpty;
            out_data <= '0;
            out_ch   <= '0;
            last_q   <= SELW'(N - 1);
        end else if (load) begin
            if (gv) begin
                state_q  <= StFull;
                out_data <= gdata;
                out_ch   <= g;
                last_q   <= g;
            end else begin
                state_q  <= StEmpty;
            end
        end
    end

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Self-checking bench for mux_nto1_rr: directed scenarios plus random stimulus
// compared against a transaction-level model of the output register and rr pointer.
module tb_mux_nto1_rr;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mode;
    logic [1:0]   sel;
    logic [3:0]   in_valid;
    logic [31:0]  in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [7:0]   out_data;
    logic [1:0]   out_ch;
    logic         out_ready;

    logic [2:0]   sel5;
    logic [4:0]   in_valid5;
    logic [39:0]  in_data5;
    logic [4:0]   in_ready5;
    logic         out_valid5;
    logic [7:0]   out_data5;
    logic [2:0]   out_ch5;

    int total = 0;
    int bad   = 0;

    bit         m_valid;
    logic [7:0] m_data;
    int         m_ch;
    int         m_last;

    always #5 clk = ~clk;

    mux_nto1_rr #(.WIDTH(8), .N(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
    );

    mux_nto1_rr #(.WIDTH(8), .N(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel5), .in_valid(in_valid5),
        .in_data(in_data5), .in_ready(in_ready5), .out_valid(out_valid5),
        .out_data(out_data5), .out_ch(out_ch5), .out_ready(out_ready)
    );

    // Channel that should win this cycle, or -1 when nobody is granted.
    function automatic int pick();
        if (mode == 1'b0) begin
            return in_valid[sel] ? int'(sel) : -1;
        end
        for (int k = 1; k <= N; k++) begin
            if (in_valid[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int c;
        if (!rst_n) return 4'b0000;
        if (m_valid && !out_ready) return 4'b0000;
        c = pick();
        if (c < 0) return 4'b0000;
        return 4'b0001 << c;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ch    = 0;
        m_last  = N - 1;
    endtask

    task automatic tick();
        int c;
        @(posedge clk);
        if (!m_valid || out_ready) begin
            c = pick();
            if (c >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[c*W +: W];
                m_ch    = c;
                m_last  = c;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b1; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
        in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        sel5 = 3'd0; in_valid5 = 5'h1F; in_data5 = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", out_data); end
        total++; if (out_ch !== 2'd0) begin bad++; $display("FAIL reset_ch got=%0d want=0", out_ch); end
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", in_ready); end
        total++; if (in_ready5 !== 5'b00000) begin bad++; $display("FAIL reset_ready5 got=%b want=00000", in_ready5); end
        in_valid5 = 5'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rr_all();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (out_ch !== 2'(i % 4) || out_valid !== 1'b1) begin
                bad++; $display("FAIL rr_all[%0d] got ch=%0d v=%b want ch=%0d v=1", i, out_ch, out_valid, i % 4);
            end
            total++; if (out_data !== 8'hA0 + 8'(i % 4)) begin
                bad++; $display("FAIL rr_all_data[%0d] got=%h want=%h", i, out_data, 8'hA0 + 8'(i % 4));
            end
        end
    endtask

    task automatic test_sparse();
        int prev;
        mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
        prev = m_last;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (out_ch !== 2'(m_ch) || out_valid !== 1'b1 || out_ch === 2'(prev)) begin
                bad++; $display("FAIL sparse[%0d] got ch=%0d v=%b want ch=%0d v=1", i, out_ch, out_valid, m_ch);
            end
            prev = m_ch;
        end
        in_valid = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (out_ch !== 2'd2 || out_valid !== 1'b1 || out_data !== 8'hA2) begin
                bad++; $display("FAIL single[%0d] got ch=%0d v=%b d=%h want ch=2 v=1 d=a2", i, out_ch, out_valid, out_data);
            end
        end
    endtask

    task automatic test_backpressure();
        mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b1;
        tick();
        total++; if (out_data !== 8'hA1 || out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_load got d=%h v=%b want d=a1 v=1", out_data, out_valid);
        end
        out_ready = 1'b0; in_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=0000", i, in_ready); end
            tick();
            total++; if (out_data !== 8'hA1 || out_ch !== 2'd1 || out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold[%0d] got d=%h ch=%0d v=%b want d=a1 ch=1 v=1", i, out_data, out_ch, out_valid);
            end
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL bp_release_ready got=%b want=0100", in_ready); end
        tick();
        total++; if (out_ch !== 2'd2 || out_data !== 8'hA2) begin
            bad++; $display("FAIL bp_release got ch=%0d d=%h want ch=2 d=a2", out_ch, out_data);
        end
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL fixed_ready got=%b want=0100", in_ready); end
        tick();
        total++; if (out_data !== 8'hA2 || out_ch !== 2'd2 || out_valid !== 1'b1) begin
            bad++; $display("FAIL fixed_out got d=%h ch=%0d v=%b want d=a2 ch=2 v=1", out_data, out_ch, out_valid);
        end
        sel = 2'd0; in_valid = 4'b1110;
        #1;
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL fixed_novalid_ready got=%b want=0000", in_ready); end
        tick();
        total++; if (out_valid !== 1'b0 || out_data !== 8'hA2) begin
            bad++; $display("FAIL fixed_novalid got v=%b d=%h want v=0 d=a2", out_valid, out_data);
        end
    endtask

    task automatic test_fixed_oor();
        mode = 1'b0; in_valid5 = 5'h1F; sel5 = 3'd4;
        tick();
        total++; if (out_valid5 !== 1'b1 || out_ch5 !== 3'd4 || out_data5 !== 8'hA4) begin
            bad++; $display("FAIL n5_sel4 got v=%b ch=%0d d=%h want v=1 ch=4 d=a4", out_valid5, out_ch5, out_data5);
        end
        sel5 = 3'd5;
        #1;
        total++; if (in_ready5 !== 5'b00000) begin bad++; $display("FAIL n5_sel5_ready got=%b want=00000", in_ready5); end
        tick();
        total++; if (out_valid5 !== 1'b0) begin bad++; $display("FAIL n5_sel5 got v=%b want v=0", out_valid5); end
        sel5 = 3'd7;
        tick();
        total++; if (out_valid5 !== 1'b0 || out_data5 !== 8'hA4 || out_ch5 !== 3'd4) begin
            bad++; $display("FAIL n5_sel7 got v=%b d=%h ch=%0d want v=0 d=a4 ch=4", out_valid5, out_data5, out_ch5);
        end
        in_valid5 = 5'h00;
    endtask

    task automatic test_random();
        logic [3:0] er;
        for (int i = 0; i < 400; i++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            #1;
            er = exp_ready();
            total++; if (in_ready !== er) begin bad++; $display("FAIL rand_ready[%0d] got=%b want=%b", i, in_ready, er); end
            tick();
            total++; if (out_valid !== m_valid || out_data !== m_data || out_ch !== 2'(m_ch)) begin
                bad++; $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                                i, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
            end
        end
        in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    endtask

    task automatic test_midreset();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre got v=%b want 1", out_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_async got v=%b want 0", out_valid); end
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL mid_ready got=%b want=0000", in_ready); end
        @(posedge clk);
        #2;
        model_reset();
        rst_n = 1'b1;
        tick();
        total++; if (out_ch !== 2'd0 || out_valid !== 1'b1 || out_data !== 8'hA0) begin
            bad++; $display("FAIL mid_after got ch=%0d v=%b d=%h want ch=0 v=1 d=a0", out_ch, out_valid, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_rr_all();
        test_sparse();
        test_backpressure();
        test_fixed();
        test_fixed_oor();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
